// File: rtl/wash_program_seq_if.sv
// ----------------------------------------------------------------------------
// wash_program_seq_if : control/status bundle for the wash program sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface wash_program_seq_if #(
  parameter int N_STAGES = 3,
  parameter int TIME_W   = 6
);
  logic                         tick;
  logic                         runBtn;
  logic                         doorOpen;
  logic [N_STAGES-1:0]          stageEn;
  logic [N_STAGES*TIME_W-1:0]   stageTime;
  logic                         fillValve;
  logic                         agitate;
  logic                         drainValve;
  logic                         spin;
  logic [2:0]                   stageIdx;
  logic [TIME_W-1:0]            remain;
  logic                         busy;
  logic                         paused;
  logic                         donePulse;
  logic                         beep;

  modport master (
    output tick, runBtn, doorOpen, stageEn, stageTime,
    input  fillValve, agitate, drainValve, spin, stageIdx, remain,
           busy, paused, donePulse, beep
  );

  modport slave (
    input  tick, runBtn, doorOpen, stageEn, stageTime,
    output fillValve, agitate, drainValve, spin, stageIdx, remain,
           busy, paused, donePulse, beep
  );
endinterface

`default_nettype wire

// File: rtl/wash_program_seq.sv
// ----------------------------------------------------------------------------
// wash_program_seq : N-stage FILL/AGITATE/DRAIN/SPIN sequencer with door pause
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wash_program_seq #(
  parameter int N_STAGES = 3,
  parameter int TIME_W   = 6,
  parameter int FILL_T   = 2,
  parameter int DRAIN_T  = 2,
  parameter int SPIN_T   = 3,
  parameter int BEEP_T   = 4
) (
  input  logic               clk,
  input  logic               resetBtn,
  wash_program_seq_if.slave  bus
);

  localparam logic [TIME_W-1:0] FILL_D  = TIME_W'(FILL_T);
  localparam logic [TIME_W-1:0] DRAIN_D = TIME_W'(DRAIN_T);
  localparam logic [TIME_W-1:0] SPIN_D  = TIME_W'(SPIN_T);
  localparam logic [TIME_W-1:0] BEEP_D  = TIME_W'(BEEP_T);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;
  typedef enum logic [1:0] {P_FILL, P_AGIT, P_DRAIN, P_SPIN} phase_t;

  state_t                      state, state_nxt;
  phase_t                      phase, phase_nxt, adv_phase;
  logic [2:0]                  stage, stage_nxt, adv_stage;
  logic [TIME_W-1:0]           rem, rem_nxt, adv_rem;
  logic [TIME_W-1:0]           beep_cnt, beep_nxt;
  logic [N_STAGES-1:0]         en_q;
  logic [N_STAGES*TIME_W-1:0]  time_q;
  logic                        start, adv_done;
  logic [3:0]                  start_sel, next_sel;

  // Lowest enabled stage at or above lo; bit 3 set means none found.
  function automatic logic [3:0] lowest_from(input logic [N_STAGES-1:0] mask,
                                              input logic [3:0] lo);
    logic [3:0] res;
    res = 4'b1000;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= lo)) res = {1'b0, 3'(i)};
    end
    return res;
  endfunction

  function automatic logic [TIME_W-1:0] agit_time(input logic [N_STAGES*TIME_W-1:0] tm,
                                                   input logic [2:0] s);
    logic [TIME_W-1:0] t;
    t = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (3'(i) == s) t = tm[i*TIME_W +: TIME_W];
    end
    return t;
  endfunction

  assign start_sel = lowest_from(bus.stageEn, 4'd0);
  assign next_sel  = lowest_from(en_q, {1'b0, stage} + 4'd1);

  // Successor of the current sub-phase, used whenever the sub-phase expires.
  always_comb begin
    adv_phase = phase;
    adv_stage = stage;
    adv_rem   = rem;
    adv_done  = 1'b0;
    unique case (phase)
      P_FILL:  begin adv_phase = P_AGIT;  adv_rem = agit_time(time_q, stage); end
      P_AGIT:  begin adv_phase = P_DRAIN; adv_rem = DRAIN_D; end
      P_DRAIN: begin adv_phase = P_SPIN;  adv_rem = SPIN_D;  end
      P_SPIN: begin
        if (next_sel[3]) begin
          adv_done = 1'b1;
        end else begin
          adv_phase = P_FILL;
          adv_stage = next_sel[2:0];
          adv_rem   = FILL_D;
        end
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    stage_nxt = stage;
    rem_nxt   = rem;
    beep_nxt  = beep_cnt;
    start     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.runBtn && !bus.doorOpen && !start_sel[3]) begin
          start     = 1'b1;
          state_nxt = S_RUN;
          phase_nxt = P_FILL;
          stage_nxt = start_sel[2:0];
          rem_nxt   = FILL_D;
        end
      end
      S_RUN: begin
        // Pause requests take precedence; a coincident tick is dropped.
        if (bus.runBtn || bus.doorOpen) begin
          state_nxt = S_PAUSE;
        end else if ((rem == '0) || (bus.tick && (rem == TIME_W'(1)))) begin
          if (adv_done) begin
            state_nxt = S_DONE;
            phase_nxt = P_FILL;
            stage_nxt = 3'd0;
            rem_nxt   = '0;
            beep_nxt  = BEEP_D;
          end else begin
            phase_nxt = adv_phase;
            stage_nxt = adv_stage;
            rem_nxt   = adv_rem;
          end
        end else if (bus.tick) begin
          rem_nxt = rem - TIME_W'(1);
        end
      end
      S_PAUSE: begin
        if (bus.runBtn && !bus.doorOpen) state_nxt = S_RUN;
      end
      S_DONE: begin
        if (bus.runBtn || (bus.tick && (beep_cnt <= TIME_W'(1)))) begin
          state_nxt = S_IDLE;
        end else if (bus.tick) begin
          beep_nxt = beep_cnt - TIME_W'(1);
        end
      end
    endcase
  end

  // Outputs are registered from the next-state values so they never glitch.
  always_ff @(posedge clk) begin
    if (resetBtn) begin
      state          <= S_IDLE;
      phase          <= P_FILL;
      stage          <= 3'd0;
      rem            <= '0;
      beep_cnt       <= '0;
      en_q           <= '0;
      time_q         <= '0;
      bus.fillValve  <= 1'b0;
      bus.agitate    <= 1'b0;
      bus.drainValve <= 1'b0;
      bus.spin       <= 1'b0;
      bus.stageIdx   <= 3'd0;
      bus.remain     <= '0;
      bus.busy       <= 1'b0;
      bus.paused     <= 1'b0;
      bus.donePulse  <= 1'b0;
      bus.beep       <= 1'b0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      stage    <= stage_nxt;
      rem      <= rem_nxt;
      beep_cnt <= beep_nxt;
      if (start) begin
        en_q   <= bus.stageEn;
        time_q <= bus.stageTime;
      end
      bus.fillValve  <= (state_nxt == S_RUN) && (phase_nxt == P_FILL);
      bus.agitate    <= (state_nxt == S_RUN) && (phase_nxt == P_AGIT);
      bus.drainValve <= (state_nxt == S_RUN) && ((phase_nxt == P_DRAIN) || (phase_nxt == P_SPIN));
      bus.spin       <= (state_nxt == S_RUN) && (phase_nxt == P_SPIN);
      bus.stageIdx   <= ((state_nxt == S_RUN) || (state_nxt == S_PAUSE)) ? stage_nxt : 3'd0;
      bus.remain     <= ((state_nxt == S_RUN) || (state_nxt == S_PAUSE)) ? rem_nxt : '0;
      bus.busy       <= (state_nxt == S_RUN) || (state_nxt == S_PAUSE);
      bus.paused     <= (state_nxt == S_PAUSE);
      bus.donePulse  <= (state_nxt == S_DONE) && (state != S_DONE);
      bus.beep       <= (state_nxt == S_DONE);
    end
  end

endmodule

`default_nettype wire
